// File: rtl/ddr_test_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr_test_burst_ctrl_if
// Description : AXI write/read channel bundle between the DDR self-test
//               burst sequencer (master) and the DDR controller port (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr_test_burst_ctrl_if;
   logic [31:0] AwAddr;
   logic        AwValid;
   logic        AwReady;
   logic [7:0]  AwLen;
   logic        WValid;
   logic        WReady;
   logic        WLast;
   logic        BValid;
   logic [1:0]  BResp;
   logic        BReady;
   logic [31:0] ArAddr;
   logic        ArValid;
   logic        ArReady;
   logic [7:0]  ArLen;
   logic        RValid;
   logic        RLast;
   logic [1:0]  RResp;
   logic        RReady;

   modport master (
      output AwAddr, AwValid, AwLen,
      output WValid, WLast,
      output BReady,
      output ArAddr, ArValid, ArLen,
      output RReady,
      input  AwReady, WReady, BValid, BResp, ArReady, RValid, RLast, RResp
   );

   modport slave (
      input  AwAddr, AwValid, AwLen,
      input  WValid, WLast,
      input  BReady,
      input  ArAddr, ArValid, ArLen,
      input  RReady,
      output AwReady, WReady, BValid, BResp, ArReady, RValid, RLast, RResp
   );
endinterface
`default_nettype wire

// File: rtl/ddr_test_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ddr_test_burst_ctrl
// Description : AXI master sequencer for the DDR write/read-back self-test.
//               Writes INCR bursts over the test window, reads each one back
//               and feeds the pattern generator and read checker.
//               Define DDR_TEST_LOOP_EN for continuous soak passes.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_test_burst_ctrl #(
   parameter int          AXI_DATA_WIDTH = 256,
   parameter int          BURST_LEN      = 16,
   parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
   parameter logic [31:0] ADDR_RANGE     = 32'h0010_0000,
   parameter int          TIMEOUT_WIDTH  = 16
) (
   input  logic                  SysClk,
   input  logic                  SysRst,
   input  logic                  TestStart,
   ddr_test_burst_ctrl_if.master axi,
   output logic [31:0]           WrAddrOut,
   output logic                  WrStartEn,
   output logic                  WriteEn,
   output logic [31:0]           RdAddrOut,
   output logic                  RdDataEn,
   output logic                  TestBusy,
   output logic                  TestDone,
   output logic                  TestFail,
   output logic [15:0]           PassCnt
);

   localparam logic [31:0] c_abn      = 32'(AXI_DATA_WIDTH / 8);
   localparam logic [31:0] c_stride   = 32'((AXI_DATA_WIDTH / 8) * BURST_LEN);
   localparam logic [31:0] c_endAddr  = ADDR_BASE + ADDR_RANGE;
   localparam logic [7:0]  c_axLen    = 8'(BURST_LEN - 1);
   localparam logic [7:0]  c_lastBeat = 8'(BURST_LEN - 1);

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_AW   = 4'd1,
      ST_W    = 4'd2,
      ST_B    = 4'd3,
      ST_AR   = 4'd4,
      ST_R    = 4'd5,
      ST_NEXT = 4'd6,
      ST_DONE = 4'd7,
      ST_FAIL = 4'd8
   } state_t;

   state_t                   r_state;
   state_t                   w_nextState;
   logic [31:0]              r_burstAddr;
   logic [31:0]              r_rdAddr;
   logic [7:0]               r_beatCnt;
   logic [TIMEOUT_WIDTH-1:0] r_wdCnt;
   logic                     r_wrStart;
   logic [15:0]              r_passCnt;

   logic                     w_awValid;
   logic                     w_wValid;
   logic                     w_wLast;
   logic                     w_bReady;
   logic                     w_arValid;
   logic                     w_rdDataEn;
   logic                     w_active;
   logic                     w_idleLike;
   logic                     w_handshake;
   logic                     w_wdExpired;
   logic [31:0]              w_nextAddr;
   logic                     w_windowEnd;

`ifdef DDR_TEST_LOOP_EN
   logic                     r_donePulse;
`endif

   assign w_nextAddr  = r_burstAddr + c_stride;
   assign w_windowEnd = (w_nextAddr == c_endAddr);

   always_comb begin
      w_nextState = r_state;
      w_awValid   = 1'b0;
      w_wValid    = 1'b0;
      w_wLast     = 1'b0;
      w_bReady    = 1'b0;
      w_arValid   = 1'b0;
      w_rdDataEn  = 1'b0;
      w_active    = 1'b0;
      w_idleLike  = 1'b0;
      w_handshake = 1'b0;
      w_wdExpired = 1'b0;

      case (r_state)
         ST_AW: begin
            w_awValid   = 1'b1;
            w_active    = 1'b1;
            w_handshake = axi.AwReady;
         end
         ST_W: begin
            w_wValid    = 1'b1;
            w_wLast     = (r_beatCnt == c_lastBeat);
            w_active    = 1'b1;
            w_handshake = axi.WReady;
         end
         ST_B: begin
            w_bReady    = 1'b1;
            w_active    = 1'b1;
            w_handshake = axi.BValid;
         end
         ST_AR: begin
            w_arValid   = 1'b1;
            w_active    = 1'b1;
            w_handshake = axi.ArReady;
         end
         ST_R: begin
            w_rdDataEn  = axi.RValid;
            w_active    = 1'b1;
            w_handshake = axi.RValid;
         end
         ST_IDLE, ST_DONE, ST_FAIL: begin
            w_idleLike  = 1'b1;
         end
         default: begin
         end
      endcase

      w_wdExpired = w_active & (&r_wdCnt) & ~w_handshake;

      case (r_state)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (TestStart) begin
               w_nextState = ST_AW;
            end
         end
         ST_AW: begin
            if (axi.AwReady) begin
               w_nextState = ST_W;
            end
         end
         ST_W: begin
            if (axi.WReady && w_wLast) begin
               w_nextState = ST_B;
            end
         end
         ST_B: begin
            if (axi.BValid) begin
               w_nextState = (axi.BResp != 2'b00) ? ST_FAIL : ST_AR;
            end
         end
         ST_AR: begin
            if (axi.ArReady) begin
               w_nextState = ST_R;
            end
         end
         ST_R: begin
            if (axi.RValid) begin
               if ((axi.RResp != 2'b00) || (axi.RLast && (r_beatCnt != c_lastBeat))) begin
                  w_nextState = ST_FAIL;
               end else if (axi.RLast) begin
                  w_nextState = ST_NEXT;
               end
            end
         end
         ST_NEXT: begin
`ifdef DDR_TEST_LOOP_EN
            w_nextState = ST_AW;
`else
            w_nextState = w_windowEnd ? ST_DONE : ST_AW;
`endif
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase

      if (w_wdExpired) begin
         w_nextState = ST_FAIL;
      end
   end

   always_ff @(posedge SysClk) begin
      if (SysRst) begin
         r_state     <= ST_IDLE;
         r_burstAddr <= ADDR_BASE;
         r_rdAddr    <= ADDR_BASE;
         r_beatCnt   <= 8'd0;
         r_wdCnt     <= '0;
         r_wrStart   <= 1'b0;
         r_passCnt   <= 16'd0;
`ifdef DDR_TEST_LOOP_EN
         r_donePulse <= 1'b0;
`endif
      end else begin
         r_state <= w_nextState;

         // Pattern load strobe lines up with the first cycle spent in AW.
         r_wrStart <= (w_nextState == ST_AW) && (r_state != ST_AW);

         if (!w_active || w_handshake || (w_nextState != r_state)) begin
            r_wdCnt <= '0;
         end else begin
            r_wdCnt <= r_wdCnt + TIMEOUT_WIDTH'(1);
         end

         if (r_state == ST_W) begin
            if (axi.WReady) begin
               r_beatCnt <= r_beatCnt + 8'd1;
            end
         end else if (r_state == ST_R) begin
            if (axi.RValid) begin
               r_beatCnt <= r_beatCnt + 8'd1;
            end
         end else begin
            r_beatCnt <= 8'd0;
         end

         if (r_state == ST_R) begin
            if (axi.RValid) begin
               r_rdAddr <= r_rdAddr + c_abn;
            end
         end else begin
            r_rdAddr <= r_burstAddr;
         end

         if (w_idleLike && TestStart) begin
            r_burstAddr <= ADDR_BASE;
         end else if (r_state == ST_NEXT) begin
            r_burstAddr <= w_windowEnd ? ADDR_BASE : w_nextAddr;
         end

         if ((r_state == ST_NEXT) && w_windowEnd && (r_passCnt != 16'hFFFF)) begin
            r_passCnt <= r_passCnt + 16'd1;
         end

`ifdef DDR_TEST_LOOP_EN
         r_donePulse <= (r_state == ST_NEXT) && w_windowEnd;
`endif
      end
   end

   assign axi.AwAddr  = r_burstAddr;
   assign axi.AwValid = w_awValid;
   assign axi.AwLen   = c_axLen;
   assign axi.WValid  = w_wValid;
   assign axi.WLast   = w_wLast;
   assign axi.BReady  = w_bReady;
   assign axi.ArAddr  = r_burstAddr;
   assign axi.ArValid = w_arValid;
   assign axi.ArLen   = c_axLen;
   assign axi.RReady  = 1'b1;

   assign WrAddrOut = r_burstAddr;
   assign WrStartEn = r_wrStart;
   assign WriteEn   = w_wValid & axi.WReady;
   assign RdAddrOut = r_rdAddr;
   assign RdDataEn  = w_rdDataEn;
   assign TestBusy  = w_active | (r_state == ST_NEXT);
   assign TestFail  = (r_state == ST_FAIL);
   assign PassCnt   = r_passCnt;

`ifdef DDR_TEST_LOOP_EN
   assign TestDone  = r_donePulse;
`else
   assign TestDone  = (r_state == ST_DONE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_test_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_test_burst_ctrl
// Description : Directed bench for ddr_test_burst_ctrl with a reactive AXI
//               slave model; honours DDR_TEST_LOOP_EN for the soak scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_test_burst_ctrl;

   localparam int          c_adw   = 1024;
   localparam int          c_bl    = 16;
   localparam int          c_abn   = c_adw / 8;
   localparam int          c_tw    = 6;
   localparam logic [31:0] c_range = 32'h2000;

   logic        SysClk = 1'b0;
   logic        SysRst;
   logic        TestStart;
   logic [31:0] WrAddrOut;
   logic        WrStartEn;
   logic        WriteEn;
   logic [31:0] RdAddrOut;
   logic        RdDataEn;
   logic        TestBusy;
   logic        TestDone;
   logic        TestFail;
   logic [15:0] PassCnt;

   ddr_test_burst_ctrl_if axi ();

   ddr_test_burst_ctrl #(
      .AXI_DATA_WIDTH (c_adw),
      .BURST_LEN      (c_bl),
      .ADDR_BASE      (32'h0000_0000),
      .ADDR_RANGE     (c_range),
      .TIMEOUT_WIDTH  (c_tw)
   ) dut (
      .SysClk    (SysClk),
      .SysRst    (SysRst),
      .TestStart (TestStart),
      .axi       (axi),
      .WrAddrOut (WrAddrOut),
      .WrStartEn (WrStartEn),
      .WriteEn   (WriteEn),
      .RdAddrOut (RdAddrOut),
      .RdDataEn  (RdDataEn),
      .TestBusy  (TestBusy),
      .TestDone  (TestDone),
      .TestFail  (TestFail),
      .PassCnt   (PassCnt)
   );

   always #5 SysClk = ~SysClk;

   int nChecks = 0;
   int nErrors = 0;

   int          awStall, bErrBurst, bIdx, rRemain;
   bit          wToggle, wPhase, rEnable;
   int          awCount, arCount, wrEnCount, rdEnCount, wrStartCount;
   int          wLastHits, wLastBad, wBeat, rBeat, rdAddrBad;
   int          awRun, awUnstable, doneCycles;
   logic [31:0] awAddrs[$];
   int          awRuns[$];
   logic [31:0] arAddrLast, awAddrPrev;
   bit          awPrevValid;

   // Slave drives on the falling edge, then samples settled handshakes 1ns later.
   initial begin
      forever begin
         @(negedge SysClk);
         axi.AwReady = (awStall == 0);
         axi.WReady  = wToggle ? wPhase : 1'b1;
         wPhase      = ~wPhase;
         axi.BValid  = axi.BReady;
         axi.BResp   = (axi.BReady && (bIdx + 1 == bErrBurst)) ? 2'b10 : 2'b00;
         axi.RResp   = 2'b00;
         if (rEnable && rRemain > 0) begin
            axi.RValid = 1'b1;
            axi.RLast  = (rRemain == 1);
            rRemain--;
         end else begin
            axi.RValid = 1'b0;
            axi.RLast  = 1'b0;
         end
         #1;
         if (axi.AwValid) begin
            awRun++;
            if (awPrevValid && axi.AwAddr !== awAddrPrev) awUnstable++;
            awAddrPrev  = axi.AwAddr;
            awPrevValid = 1'b1;
            if (axi.AwReady) begin
               awAddrs.push_back(axi.AwAddr);
               awRuns.push_back(awRun);
               awCount++;
               awRun       = 0;
               awPrevValid = 1'b0;
            end else if (awStall > 0) begin
               awStall--;
            end
         end
         if (axi.ArValid && axi.ArReady) begin
            arCount++;
            arAddrLast = axi.ArAddr;
            rBeat      = 0;
            rRemain    = c_bl;
         end
         if (axi.BValid && axi.BReady) bIdx++;
         if (WrStartEn) wrStartCount++;
         if (WriteEn) begin
            wrEnCount++;
            wBeat++;
            if (axi.WLast) begin
               if (wBeat == c_bl) wLastHits++;
               else wLastBad++;
               wBeat = 0;
            end
         end
         if (RdDataEn) begin
            rdEnCount++;
            if (RdAddrOut !== arAddrLast + 32'(rBeat * c_abn)) rdAddrBad++;
            rBeat++;
         end
         if (TestDone) doneCycles++;
      end
   end

   task automatic clear_stats();
      awStall = 0; bErrBurst = 0; bIdx = 0; rRemain = 0;
      wToggle = 1'b0; wPhase = 1'b1; rEnable = 1'b1;
      awCount = 0; arCount = 0; wrEnCount = 0; rdEnCount = 0; wrStartCount = 0;
      wLastHits = 0; wLastBad = 0; wBeat = 0; rBeat = 0; rdAddrBad = 0;
      awRun = 0; awUnstable = 0; doneCycles = 0; awPrevValid = 1'b0;
      arAddrLast = 32'h0; awAddrPrev = 32'h0;
      awAddrs.delete();
      awRuns.delete();
   endtask

   task automatic pulse_start();
      @(negedge SysClk);
      TestStart = 1'b1;
      @(negedge SysClk);
      TestStart = 1'b0;
   endtask

   // cyc counts negedges with cycle 1 being the first AW cycle.
   task automatic run_pass(output int cyc);
      pulse_start();
      cyc = 1;
      while (!TestDone && !TestFail && cyc < 2000) begin
         @(negedge SysClk);
         cyc++;
      end
      #2;
   endtask

   task automatic test_reset();
      SysRst = 1'b1;
      repeat (2) @(negedge SysClk);
      nChecks++;
      if ({TestBusy, TestDone, TestFail} !== 3'b000) begin
         nErrors++; $display("FAIL reset_status: got %b expected 000", {TestBusy, TestDone, TestFail});
      end
      nChecks++;
      if (PassCnt !== 16'd0) begin
         nErrors++; $display("FAIL reset_passcnt: got %0d expected 0", PassCnt);
      end
      nChecks++;
      if ({axi.AwValid, axi.WValid, axi.ArValid, axi.BReady, axi.WLast} !== 5'b0) begin
         nErrors++; $display("FAIL reset_valids: got %b expected 00000",
                             {axi.AwValid, axi.WValid, axi.ArValid, axi.BReady, axi.WLast});
      end
      nChecks++;
      if ({WrStartEn, WriteEn, RdDataEn} !== 3'b000) begin
         nErrors++; $display("FAIL reset_strobes: got %b expected 000", {WrStartEn, WriteEn, RdDataEn});
      end
      nChecks++;
      if ((axi.AwAddr | axi.ArAddr | WrAddrOut | RdAddrOut) !== 32'h0) begin
         nErrors++; $display("FAIL reset_addr: got %h/%h/%h/%h expected 0",
                             axi.AwAddr, axi.ArAddr, WrAddrOut, RdAddrOut);
      end
      nChecks++;
      if (axi.AwLen !== 8'd15 || axi.ArLen !== 8'd15) begin
         nErrors++; $display("FAIL reset_axlen: got %0d/%0d expected 15", axi.AwLen, axi.ArLen);
      end
      SysRst = 1'b0;
      @(negedge SysClk);
   endtask

   task automatic test_single_pass();
      int cyc;
      bit bad;
      clear_stats();
      run_pass(cyc);
      nChecks++;
      if (TestDone !== 1'b1 || TestFail !== 1'b0 || TestBusy !== 1'b0) begin
         nErrors++; $display("FAIL pass_status: got done=%b fail=%b busy=%b expected 1/0/0", TestDone, TestFail, TestBusy);
      end
      nChecks++;
      if (cyc != 145) begin
         nErrors++; $display("FAIL pass_latency: got %0d expected 145", cyc);
      end
      nChecks++;
      if (PassCnt !== 16'd1) begin
         nErrors++; $display("FAIL pass_passcnt: got %0d expected 1", PassCnt);
      end
      bad = (awCount != 4);
      for (int k = 0; k < 4 && !bad; k++) if (awAddrs[k] !== 32'(k * 32'h800)) bad = 1'b1;
      nChecks++;
      if (bad) begin
         nErrors++; $display("FAIL pass_aw_addrs: got count %0d expected 4 at 0/800/1000/1800", awCount);
      end
      nChecks++;
      if (wrEnCount != 64 || rdEnCount != 64) begin
         nErrors++; $display("FAIL pass_beats: got wr=%0d rd=%0d expected 64/64", wrEnCount, rdEnCount);
      end
      nChecks++;
      if (rdAddrBad != 0) begin
         nErrors++; $display("FAIL pass_rdaddr: got %0d bad beat addresses expected 0", rdAddrBad);
      end
      nChecks++;
      if (wrStartCount != 4) begin
         nErrors++; $display("FAIL pass_wrstart: got %0d expected 4", wrStartCount);
      end
      repeat (5) @(negedge SysClk);
      nChecks++;
      if (TestDone !== 1'b1 || TestBusy !== 1'b0) begin
         nErrors++; $display("FAIL pass_done_level: got done=%b busy=%b expected 1/0", TestDone, TestBusy);
      end
   endtask

   task automatic test_aw_stall();
      int cyc;
      clear_stats();
      awStall = 10;
      run_pass(cyc);
      nChecks++;
      if (awRuns.size() < 2 || awRuns[0] != 11 || awRuns[1] != 1) begin
         nErrors++; $display("FAIL stall_aw_run: got first run %0d expected 11 then 1",
                             (awRuns.size() > 0) ? awRuns[0] : -1);
      end
      nChecks++;
      if (awUnstable != 0) begin
         nErrors++; $display("FAIL stall_aw_stable: got %0d address changes expected 0", awUnstable);
      end
      nChecks++;
      if (wrStartCount != 4) begin
         nErrors++; $display("FAIL stall_wrstart: got %0d expected 4", wrStartCount);
      end
      nChecks++;
      if (cyc != 155 || PassCnt !== 16'd2) begin
         nErrors++; $display("FAIL stall_latency: got cyc=%0d passcnt=%0d expected 155/2", cyc, PassCnt);
      end
   endtask

   task automatic test_wready_toggle();
      int cyc;
      clear_stats();
      wToggle = 1'b1;
      run_pass(cyc);
      wToggle = 1'b0;
      nChecks++;
      if (wLastHits != 4 || wLastBad != 0) begin
         nErrors++; $display("FAIL toggle_wlast: got hits=%0d bad=%0d expected 4/0", wLastHits, wLastBad);
      end
      nChecks++;
      if (wrEnCount != 64) begin
         nErrors++; $display("FAIL toggle_writeen: got %0d expected 64", wrEnCount);
      end
      nChecks++;
      if (TestDone !== 1'b1 || PassCnt !== 16'd3) begin
         nErrors++; $display("FAIL toggle_done: got done=%b passcnt=%0d expected 1/3", TestDone, PassCnt);
      end
   endtask

   task automatic test_start_ignored();
      int cyc;
      clear_stats();
      pulse_start();
      repeat (50) @(negedge SysClk);
      nChecks++;
      if (TestBusy !== 1'b1) begin
         nErrors++; $display("FAIL busy_mid_pass: got %b expected 1", TestBusy);
      end
      TestStart = 1'b1;
      @(negedge SysClk);
      TestStart = 1'b0;
      cyc = 0;
      while (!TestDone && !TestFail && cyc < 2000) begin
         @(negedge SysClk);
         cyc++;
      end
      #2;
      nChecks++;
      if (awCount != 4 || awAddrs[awAddrs.size() - 1] !== 32'h1800) begin
         nErrors++; $display("FAIL busy_start_ignored: got aw count %0d expected 4 ending at 1800", awCount);
      end
      nChecks++;
      if (PassCnt !== 16'd4) begin
         nErrors++; $display("FAIL busy_passcnt: got %0d expected 4", PassCnt);
      end
   endtask

   task automatic test_bresp_error();
      int cyc;
      clear_stats();
      bErrBurst = 2;
      pulse_start();
      cyc = 1;
      while (!TestFail && cyc < 500) begin
         @(negedge SysClk);
         cyc++;
      end
      #2;
      nChecks++;
      if (TestFail !== 1'b1 || TestDone !== 1'b0 || TestBusy !== 1'b0) begin
         nErrors++; $display("FAIL bresp_status: got fail=%b done=%b busy=%b expected 1/0/0", TestFail, TestDone, TestBusy);
      end
      nChecks++;
      if (arCount != 1 || awCount != 2) begin
         nErrors++; $display("FAIL bresp_no_ar: got ar=%0d aw=%0d expected 1/2", arCount, awCount);
      end
      repeat (3) @(negedge SysClk);
      nChecks++;
      if ({axi.AwValid, axi.WValid, axi.ArValid, axi.BReady, TestFail} !== 5'b00001) begin
         nErrors++; $display("FAIL bresp_sticky: got %b expected 00001",
                             {axi.AwValid, axi.WValid, axi.ArValid, axi.BReady, TestFail});
      end
      clear_stats();
      run_pass(cyc);
      nChecks++;
      if (awCount != 4 || awAddrs[0] !== 32'h0) begin
         nErrors++; $display("FAIL bresp_rerun_addr: got aw count %0d expected 4 starting at 0", awCount);
      end
      nChecks++;
      if (TestDone !== 1'b1 || TestFail !== 1'b0 || PassCnt !== 16'd5) begin
         nErrors++; $display("FAIL bresp_rerun_done: got done=%b fail=%b passcnt=%0d expected 1/0/5",
                             TestDone, TestFail, PassCnt);
      end
   endtask

   task automatic test_watchdog();
      int cyc;
      clear_stats();
      rEnable = 1'b0;
      pulse_start();
      cyc = 1;
      while (!TestFail && cyc < 300) begin
         @(negedge SysClk);
         cyc++;
      end
      #2;
      nChecks++;
      if (cyc != 84) begin
         nErrors++; $display("FAIL wd_latency: got %0d expected 84", cyc);
      end
      nChecks++;
      if (TestFail !== 1'b1 || TestBusy !== 1'b0) begin
         nErrors++; $display("FAIL wd_status: got fail=%b busy=%b expected 1/0", TestFail, TestBusy);
      end
      @(negedge SysClk);
      nChecks++;
      if ({axi.AwValid, axi.WValid, axi.ArValid, axi.BReady} !== 4'b0000) begin
         nErrors++; $display("FAIL wd_valids: got %b expected 0000", {axi.AwValid, axi.WValid, axi.ArValid, axi.BReady});
      end
      SysRst = 1'b1;
      clear_stats();
      @(negedge SysClk);
      nChecks++;
      if ({TestBusy, TestDone, TestFail} !== 3'b000 || PassCnt !== 16'd0) begin
         nErrors++; $display("FAIL wd_reset_clear: got status=%b passcnt=%0d expected 000/0",
                             {TestBusy, TestDone, TestFail}, PassCnt);
      end
      SysRst = 1'b0;
      @(negedge SysClk);
   endtask

   task automatic test_loop();
      int cyc;
      clear_stats();
      pulse_start();
      cyc = 1;
      while (PassCnt != 16'd3 && !TestFail && cyc < 2000) begin
         @(negedge SysClk);
         cyc++;
      end
      repeat (4) @(negedge SysClk);
      #2;
      nChecks++;
      if (doneCycles != 3) begin
         nErrors++; $display("FAIL loop_done_pulses: got %0d expected 3", doneCycles);
      end
      nChecks++;
      if (PassCnt !== 16'd3 || TestBusy !== 1'b1 || TestFail !== 1'b0) begin
         nErrors++; $display("FAIL loop_status: got passcnt=%0d busy=%b fail=%b expected 3/1/0",
                             PassCnt, TestBusy, TestFail);
      end
      nChecks++;
      if (awCount < 13 || awAddrs[4] !== 32'h0 || awAddrs[8] !== 32'h0 || awAddrs[12] !== 32'h0) begin
         nErrors++; $display("FAIL loop_aw_wrap: got aw count %0d expected >=13 wrapping to 0", awCount);
      end
      SysRst = 1'b1;
      @(negedge SysClk);
      nChecks++;
      if (TestBusy !== 1'b0 || PassCnt !== 16'd0) begin
         nErrors++; $display("FAIL loop_reset: got busy=%b passcnt=%0d expected 0/0", TestBusy, PassCnt);
      end
      SysRst = 1'b0;
      @(negedge SysClk);
   endtask

   initial begin
      SysRst      = 1'b1;
      TestStart   = 1'b0;
      axi.AwReady = 1'b1;
      axi.WReady  = 1'b1;
      axi.BValid  = 1'b0;
      axi.BResp   = 2'b00;
      axi.ArReady = 1'b1;
      axi.RValid  = 1'b0;
      axi.RLast   = 1'b0;
      axi.RResp   = 2'b00;
      clear_stats();
      test_reset();
`ifdef DDR_TEST_LOOP_EN
      test_loop();
`else
      test_single_pass();
      test_aw_stall();
      test_wready_toggle();
      test_start_ignored();
      test_bresp_error();
      test_watchdog();
`endif
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
`default_nettype wire
